// File: rtl/ieeedrv_track_sched.sv
// Shares one SD block-transfer port between NDRV drive units, issuing dirty-track saves before loads.
// Define IEEEDRV_SCHED_RR_EN for round-robin arbitration (default: lowest unit index wins).
module ieeedrv_track_sched #(
    parameter int          NDRV    = 2,
    parameter logic [19:0] TIMEOUT = 20'hF_FFFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [NDRV-1:0]   drv_mounted,
    input  logic [NDRV-1:0]   drv_save,
    input  logic [NDRV-1:0]   drv_changing,
    input  logic [8*NDRV-1:0] drv_track,
    output logic              sd_rd,
    output logic              sd_wr,
    output logic [1:0]        sd_drv,
    output logic [7:0]        sd_track,
    input  logic              sd_ack,
    input  logic              sd_done,
    output logic [NDRV-1:0]   drv_busy,
    output logic [NDRV-1:0]   drv_error
);
    localparam logic [7:0] NO_TRACK = 8'hFF;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

    state_t          state_q, state_d;
    logic            sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
    logic            op_save_q, op_save_d, abandon_q, abandon_d, init_q, init_d;
    logic [1:0]      sd_drv_q, sd_drv_d;
    logic [7:0]      sd_track_q, sd_track_d;
    logic [19:0]     cnt_q, cnt_d;
    logic [NDRV-1:0] save_old_q, save_old_d, save_pend_q, save_pend_d;
    logic [NDRV-1:0] mounted_q, mounted_d, drv_error_q, drv_error_d, drv_busy_q, drv_busy_d;
    logic [7:0]      cur_track_q [NDRV];
    logic [7:0]      cur_track_d [NDRV];
`ifdef IEEEDRV_SCHED_RR_EN
    logic [1:0]      ptr_q, ptr_d;
`endif

    logic [NDRV-1:0] fall, toggle, load_need, eligible, cur_oh, win_oh;
    logic [NDRV-1:0] pend_clr, err_set;
    logic [1:0]      win;
    logic            win_save, ld_en, fin, timed_out;
    logic [7:0]      win_cur, win_trk;

    // Per-unit status; save_old is ignored until it has been sampled once after reset.
    always_comb begin
        fall   = mounted_q & ~drv_mounted;
        toggle = init_q ? (drv_save ^ save_old_q) : '0;
        for (int i = 0; i < NDRV; i++) begin
            load_need[i] = drv_mounted[i] & ~drv_changing[i] & (drv_track[8*i +: 8] != cur_track_q[i]);
            cur_oh[i]    = (sd_drv_q == 2'(i));
        end
        eligible = save_pend_q | load_need;
    end

    always_comb begin
        win = '0;
`ifdef IEEEDRV_SCHED_RR_EN
        for (int k = NDRV - 1; k >= 0; k--)
            for (int i = 0; i < NDRV; i++)
                if (eligible[i] && i == (int'(ptr_q) + k) % NDRV) win = 2'(i);
`else
        for (int i = NDRV - 1; i >= 0; i--)
            if (eligible[i]) win = 2'(i);
`endif
        win_save = 1'b0;
        win_cur  = NO_TRACK;
        win_trk  = '0;
        for (int i = 0; i < NDRV; i++) begin
            win_oh[i] = (win == 2'(i));
            if (win_oh[i]) begin
                win_save = save_pend_q[i];
                win_cur  = cur_track_q[i];
                win_trk  = drv_track[8*i +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        sd_rd_d    = sd_rd_q;
        sd_wr_d    = sd_wr_q;
        sd_drv_d   = sd_drv_q;
        sd_track_d = sd_track_q;
        op_save_d  = op_save_q;
        abandon_d  = abandon_q;
        cnt_d      = cnt_q;
        pend_clr   = '0;
        err_set    = '0;
        ld_en      = 1'b0;
        fin        = 1'b0;
        timed_out  = 1'b0;
`ifdef IEEEDRV_SCHED_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    if (win_save && win_cur == NO_TRACK) begin
                        pend_clr = win_oh;  // nothing loaded, so nothing to write back
                    end else begin
                        state_d    = ST_REQ;
                        sd_drv_d   = win;
                        op_save_d  = win_save;
                        sd_track_d = win_save ? win_cur : win_trk;
                        sd_wr_d    = win_save;
                        sd_rd_d    = ~win_save;
                        abandon_d  = |(fall & win_oh);
                    end
                end
            end
            ST_REQ: begin
                abandon_d = abandon_q | (|(fall & cur_oh));
                if (sd_ack) begin
                    state_d = ST_XFER;
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                abandon_d = abandon_q | (|(fall & cur_oh));
                if (sd_done) begin
                    fin = 1'b1;
                end else if (ce) begin
                    if (cnt_q == TIMEOUT - 20'd1) begin
                        fin       = 1'b1;
                        timed_out = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end
                if (fin) begin
                    state_d = ST_IDLE;
`ifdef IEEEDRV_SCHED_RR_EN
                    ptr_d   = 2'((int'(sd_drv_q) + 1) % NDRV);
`endif
                    // A unit unmounted mid-transfer keeps its freshly cleared state.
                    if (!abandon_d) begin
                        if (op_save_q || timed_out) pend_clr = cur_oh;
                        if (timed_out) err_set = cur_oh;
                        ld_en = ~op_save_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < NDRV; i++) begin
            save_pend_d[i] = (save_pend_q[i] & ~pend_clr[i]) | toggle[i];
            cur_track_d[i] = (ld_en && cur_oh[i]) ? sd_track_q : cur_track_q[i];
            drv_error_d[i] = drv_error_q[i] | err_set[i];
            if (fall[i]) begin
                save_pend_d[i] = 1'b0;
                cur_track_d[i] = NO_TRACK;
                drv_error_d[i] = 1'b0;
            end
            drv_busy_d[i] = eligible[i] | ((state_q != ST_IDLE) & cur_oh[i]);
        end
        save_old_d = drv_save;
        mounted_d  = drv_mounted;
        init_d     = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            sd_drv_q    <= '0;
            sd_track_q  <= '0;
            op_save_q   <= 1'b0;
            abandon_q   <= 1'b0;
            init_q      <= 1'b0;
            cnt_q       <= '0;
            save_old_q  <= '0;
            save_pend_q <= '0;
            mounted_q   <= '0;
            drv_error_q <= '0;
            drv_busy_q  <= '0;
            // NOTE: cur_track is a few flops per unit, not a RAM, so it takes a real reset value.
            for (int i = 0; i < NDRV; i++) cur_track_q[i] <= NO_TRACK;
`ifdef IEEEDRV_SCHED_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sd_rd_q     <= sd_rd_d;
            sd_wr_q     <= sd_wr_d;
            sd_drv_q    <= sd_drv_d;
            sd_track_q  <= sd_track_d;
            op_save_q   <= op_save_d;
            abandon_q   <= abandon_d;
            init_q      <= init_d;
            cnt_q       <= cnt_d;
            save_old_q  <= save_old_d;
            save_pend_q <= save_pend_d;
            mounted_q   <= mounted_d;
            drv_error_q <= drv_error_d;
            drv_busy_q  <= drv_busy_d;
            for (int i = 0; i < NDRV; i++) cur_track_q[i] <= cur_track_d[i];
`ifdef IEEEDRV_SCHED_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign sd_rd     = sd_rd_q;
    assign sd_wr     = sd_wr_q;
    assign sd_drv    = sd_drv_q;
    assign sd_track  = sd_track_q;
    assign drv_busy  = drv_busy_q;
    assign drv_error = drv_error_q;
endmodule

// File: tb/tb_ieeedrv_track_sched.sv
// Bench for ieeedrv_track_sched: directed scenarios plus random traffic, every cycle compared
// against a transaction-level reference model of the scheduling rules.
module tb_ieeedrv_track_sched;
    localparam int          NDRV = 2;
    localparam logic [19:0] TMO  = 20'd8;

    logic              clk_sys = 1'b0, reset_n = 1'b0, ce = 1'b1;
    logic [NDRV-1:0]   drv_mounted = '0, drv_save = '0, drv_changing = '0;
    logic [8*NDRV-1:0] drv_track = '0;
    logic              sd_rd, sd_wr, sd_ack = 1'b0, sd_done = 1'b0;
    logic [1:0]        sd_drv;
    logic [7:0]        sd_track;
    logic [NDRV-1:0]   drv_busy, drv_error;

    int n_checks = 0, n_pass = 0;

    always #5 clk_sys = ~clk_sys;

    ieeedrv_track_sched #(.NDRV(NDRV), .TIMEOUT(TMO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce),
        .drv_mounted(drv_mounted), .drv_save(drv_save), .drv_changing(drv_changing),
        .drv_track(drv_track), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_drv(sd_drv),
        .sd_track(sd_track), .sd_ack(sd_ack), .sd_done(sd_done),
        .drv_busy(drv_busy), .drv_error(drv_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: what each unit still owes and which transfer is outstanding.
    int m_cur[NDRV];
    bit m_pend[NDRV], m_prev_save[NDRV], m_prev_mnt[NDRV], m_err[NDRV], m_busy[NDRV];
    bit m_armed, m_is_save, m_lost;
    int m_phase;   // 0 waiting for work, 1 request posted, 2 data moving
    int m_unit, m_trk, m_ticks, m_next;

    function automatic int trk_of(input int i);
        return int'(drv_track[8*i +: 8]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDRV; i++) begin
            m_cur[i] = 255; m_pend[i] = 0; m_prev_save[i] = 0; m_prev_mnt[i] = 0;
            m_err[i] = 0; m_busy[i] = 0;
        end
        m_armed = 0; m_is_save = 0; m_lost = 0;
        m_phase = 0; m_unit = 0; m_trk = 0; m_ticks = 0; m_next = 0;
    endtask

    task automatic model_step();
        bit fall[NDRV], want[NDRV], tog[NDRV], clr[NDRV];
        int pick;
        bit finished, expired;
        for (int i = 0; i < NDRV; i++) begin
            fall[i] = m_prev_mnt[i] && !drv_mounted[i];
            want[i] = m_pend[i] || (drv_mounted[i] && !drv_changing[i] && trk_of(i) != m_cur[i]);
            tog[i]  = m_armed && (drv_save[i] != m_prev_save[i]);
            clr[i]  = 0;
        end
        for (int i = 0; i < NDRV; i++) m_busy[i] = want[i] || (m_phase != 0 && m_unit == i);
        pick = -1;
`ifdef IEEEDRV_SCHED_RR_EN
        for (int k = 0; k < NDRV; k++)
            if (pick < 0 && want[(m_next + k) % NDRV]) pick = (m_next + k) % NDRV;
`else
        for (int j = 0; j < NDRV; j++)
            if (pick < 0 && want[j]) pick = j;
`endif
        finished = 0; expired = 0;
        if (m_phase == 0) begin
            if (pick >= 0) begin
                if (m_pend[pick] && m_cur[pick] == 255) clr[pick] = 1;
                else begin
                    m_phase = 1; m_unit = pick; m_is_save = m_pend[pick];
                    m_trk = m_is_save ? m_cur[pick] : trk_of(pick);
                    m_lost = fall[pick];
                end
            end
        end else begin
            m_lost = m_lost || fall[m_unit];
            if (m_phase == 1) begin
                if (sd_ack) begin m_phase = 2; m_ticks = 0; end
            end else begin
                if (sd_done) finished = 1;
                else if (ce) begin
                    m_ticks++;
                    if (m_ticks == int'(TMO)) begin finished = 1; expired = 1; end
                end
                if (finished) begin
                    m_phase = 0;
                    m_next = (m_unit + 1) % NDRV;
                    if (!m_lost) begin
                        if (m_is_save || expired) clr[m_unit] = 1;
                        if (!m_is_save) m_cur[m_unit] = m_trk;
                        if (expired) m_err[m_unit] = 1;
                    end
                end
            end
        end
        for (int i = 0; i < NDRV; i++) begin
            if (clr[i]) m_pend[i] = 0;
            if (tog[i]) m_pend[i] = 1;
            if (fall[i]) begin m_pend[i] = 0; m_cur[i] = 255; m_err[i] = 0; end
            m_prev_save[i] = drv_save[i];
            m_prev_mnt[i]  = drv_mounted[i];
        end
        m_armed = 1;
    endtask

    function automatic logic [NDRV-1:0] pack(input bit a[NDRV]);
        logic [NDRV-1:0] v;
        for (int i = 0; i < NDRV; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic compare_all();
        check("sd_rd", sd_rd, (m_phase == 1 && !m_is_save));
        check("sd_wr", sd_wr, (m_phase == 1 && m_is_save));
        check("sd_drv", sd_drv, m_unit);
        check("sd_track", sd_track, m_trk);
        check("drv_busy", drv_busy, pack(m_busy));
        check("drv_error", drv_error, pack(m_err));
    endtask

    // SD host responder: acks posted requests and completes them after a short delay.
    int rs = 0, ack_dly = -1, done_dly = 0, drop_pct = 0;
    bit drop = 0, force_drop = 0;

    task automatic respond();
        sd_ack = 0; sd_done = 0;
        if (!reset_n) begin rs = 0; ack_dly = -1; return; end
        if ((sd_rd | sd_wr) === 1'b1) begin
            if (ack_dly < 0) ack_dly = int'($urandom_range(0, 2));
            if (ack_dly == 0) begin
                sd_ack = 1; rs = 1; ack_dly = -1;
                done_dly = int'($urandom_range(0, 3));
                drop = force_drop || ($urandom_range(0, 99) < drop_pct);
            end else ack_dly--;
        end else if (rs == 1 && !drop) begin
            if (done_dly == 0) begin sd_done = 1; rs = 0; end
            else done_dly--;
        end
    endtask

    task automatic cyc();
        if (!reset_n) model_reset(); else model_step();
        @(posedge clk_sys);
        @(negedge clk_sys);
        compare_all();
        respond();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic count_req(input int n, output int nrd, output int nwr);
        nrd = 0; nwr = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (sd_rd === 1'b1) nrd++;
            if (sd_wr === 1'b1) nwr++;
        end
    endtask

    // Waits (bounded) for the next freshly posted request.
    task automatic wait_req(input string tag);
        int n = 0;
        while ((sd_rd | sd_wr) === 1'b1 && n < 40) begin cyc(); n++; end
        n = 0;
        while ((sd_rd | sd_wr) !== 1'b1 && n < 40) begin cyc(); n++; end
        check({tag, "_seen"}, (sd_rd | sd_wr), 1);
    endtask

    task automatic async_reset();
        #2 reset_n = 0;
        model_reset();
        sd_ack = 0; sd_done = 0; rs = 0; ack_dly = -1;
        #1;
        check("arst_rd", sd_rd, 0);
        check("arst_wr", sd_wr, 0);
        check("arst_drv", sd_drv, 0);
        check("arst_track", sd_track, 0);
        check("arst_busy", drv_busy, 0);
        check("arst_err", drv_error, 0);
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        run(2);
        reset_n = 1;
    endtask

    int nrd, nwr;
    int grants[4];

    initial begin
        model_reset();
        drv_save = 2'b01;
        run(3);
        reset_n = 1;
        run(3);

        // Mount unit 0 at track 18: a single load.
        drv_mounted[0] = 1; drv_track[7:0] = 8'd18;
        wait_req("s1");
        check("s1_rd", sd_rd, 1);
        check("s1_drv", sd_drv, 0);
        check("s1_track", sd_track, 18);
        run(10);
        check("s1_idle_busy", drv_busy[0], 0);

        // Dirty track 18 written back before track 19 is loaded.
        drv_save[0] = ~drv_save[0];
        cyc();
        drv_track[7:0] = 8'd19;
        wait_req("s2a");
        check("s2_wr", sd_wr, 1);
        check("s2_wr_track", sd_track, 18);
        wait_req("s2b");
        check("s2_rd", sd_rd, 1);
        check("s2_rd_track", sd_track, 19);
        run(10);

        // Head moving: no load until the track settles, then one load of the final track.
        drv_changing[0] = 1;
        nrd = 0;
        for (int t = 20; t <= 25; t++) begin
            drv_track[7:0] = 8'(t);
            cyc();
            if (sd_rd === 1'b1) nrd++;
        end
        check("s3_no_rd_moving", nrd, 0);
        drv_changing[0] = 0;
        wait_req("s3");
        check("s3_track", sd_track, 25);
        count_req(12, nrd, nwr);
        check("s3_single_load", nrd > 0 && nrd <= 3, 1);

        // Both units keep needing loads: arbitration order from a fresh pointer.
        pulse_reset();
        drv_mounted = 2'b11; drv_track = {8'd40, 8'd30};
        for (int g = 0; g < 4; g++) begin
            wait_req("s4");
            grants[g] = int'(sd_drv);
            drv_track[8*grants[g] +: 8] = 8'(50 + g);
        end
`ifdef IEEEDRV_SCHED_RR_EN
        check("s4_g0", grants[0], 0); check("s4_g1", grants[1], 1);
        check("s4_g2", grants[2], 0); check("s4_g3", grants[3], 1);
`else
        check("s4_g0", grants[0], 0); check("s4_g1", grants[1], 0);
        check("s4_g2", grants[2], 0); check("s4_g3", grants[3], 0);
`endif
        run(30);

        // Save on unit 1 never completes: timeout sets the error, no reissue, unmount clears it.
        force_drop = 1; ce = 1;
        drv_save[1] = ~drv_save[1];
        wait_req("s5");
        check("s5_wr", sd_wr, 1);
        check("s5_drv", sd_drv, 1);
        run(int'(TMO) + 6);
        check("s5_err", drv_error[1], 1);
        count_req(10, nrd, nwr);
        check("s5_no_reissue", nrd + nwr, 0);
        force_drop = 0;
        drv_mounted[1] = 0;
        run(2);
        check("s5_err_cleared", drv_error[1], 0);

        // Reset during a transfer: outputs clear at once, toggle seen during reset is not a save.
        force_drop = 1;
        drv_mounted[1] = 1; drv_track[15:8] = 8'd7;
        wait_req("s6");
        run(4);
        async_reset();
        drv_save[0] = ~drv_save[0];
        run(2);
        force_drop = 0;
        reset_n = 1;
        count_req(16, nrd, nwr);
        check("s6_no_save", nwr, 0);
        run(12);

        // Random traffic against the model.
        drop_pct = 10;
        for (int c = 0; c < 1500; c++) begin
            ce = 1'($urandom_range(0, 1));
            for (int i = 0; i < NDRV; i++) begin
                if ($urandom_range(0, 99) < 2) drv_mounted[i] = ~drv_mounted[i];
                if ($urandom_range(0, 99) < 5) drv_save[i] = ~drv_save[i];
                drv_changing[i] = ($urandom_range(0, 99) < 20);
                if ($urandom_range(0, 99) < 6)
                    drv_track[8*i +: 8] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
